// File: rtl/cost_table.sv
// Cost table for a job-assignment machine: 64 x 7-bit entries loaded as a stream
// and read combinationally by {W,J}. Define COST_CHECKSUM_EN to add a running checksum.
module cost_table (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    input  logic [6:0] in_data,
    output logic       in_ready,
    input  logic       clear,
    input  logic [2:0] W,
    input  logic [2:0] J,
    output logic [6:0] Cost,
    output logic       table_ready,
    output logic       load_done,
    output logic       drop_err
`ifdef COST_CHECKSUM_EN
    ,
    output logic [12:0] checksum
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_e;

    state_e     state_q;
    logic [5:0] cnt_q;
    logic       table_ready_q;
    logic       load_done_q;
    logic       drop_err_q;
    logic [6:0] mem_q [64];
    logic       accept;

    assign in_ready = (state_q != S_READY) && !clear;
    assign accept   = in_valid && in_ready;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the FSM and its outputs update together in one block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_EMPTY;
            cnt_q         <= 6'd0;
            table_ready_q <= 1'b0;
            load_done_q   <= 1'b0;
            drop_err_q    <= 1'b0;
        end else if (clear) begin
            state_q       <= S_EMPTY;
            cnt_q         <= 6'd0;
            table_ready_q <= 1'b0;
            load_done_q   <= 1'b0;
            drop_err_q    <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (accept) begin
                cnt_q <= cnt_q + 6'd1;
                case (state_q)
                    S_EMPTY: state_q <= S_LOAD;
                    S_LOAD: begin
                        // Beat 63 completes the table; the counter wraps to 0 here.
                        if (cnt_q == 6'd63) begin
                            state_q       <= S_READY;
                            table_ready_q <= 1'b1;
                            load_done_q   <= 1'b1;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
            if (in_valid && (state_q == S_READY)) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    // NOTE: the array has no reset; Cost is gated by table_ready, so stale
    // contents are never visible and the storage stays a plain register file.
    always_ff @(posedge CLK) begin
        if (accept && !RST) begin
            mem_q[cnt_q] <= in_data;
        end
    end

`ifdef COST_CHECKSUM_EN
    logic [12:0] checksum_q;

    // 64 * 127 = 8128 fits in 13 bits, so the sum never overflows.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            checksum_q <= 13'd0;
        end else if (accept) begin
            checksum_q <= checksum_q + {6'd0, in_data};
        end
    end

    assign checksum = checksum_q;
`endif

    assign Cost        = table_ready_q ? mem_q[{W, J}] : 7'd0;
    assign table_ready = table_ready_q;
    assign load_done   = load_done_q;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_cost_table.sv
// Scoreboard bench for cost_table: stimulus queues expected outputs, a negedge
// monitor pops and compares them whenever a probe cycle is flagged.
module tb_cost_table;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [6:0]  in_data;
    logic        in_ready;
    logic        clear;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        table_ready;
    logic        load_done;
    logic        drop_err;
`ifdef COST_CHECKSUM_EN
    logic [12:0] checksum;
`endif

    cost_table dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .clear       (clear),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .table_ready (table_ready),
        .load_done   (load_done),
        .drop_err    (drop_err)
`ifdef COST_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [6:0]  cost;
        logic        tr;
        logic        ir;
        logic        ld;
        logic        de;
        logic [12:0] cs;
    } exp_t;

    exp_t sb_q[$];
    logic probe_en = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    always @(negedge CLK) begin
        if (probe_en) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, ".cost"},        {9'd0, Cost},        {9'd0, e.cost});
                check({e.name, ".table_ready"}, {15'd0, table_ready}, {15'd0, e.tr});
                check({e.name, ".in_ready"},    {15'd0, in_ready},    {15'd0, e.ir});
                check({e.name, ".load_done"},   {15'd0, load_done},   {15'd0, e.ld});
                check({e.name, ".drop_err"},    {15'd0, drop_err},    {15'd0, e.de});
`ifdef COST_CHECKSUM_EN
                check({e.name, ".checksum"},    {3'd0, checksum},     {3'd0, e.cs});
`endif
            end
        end
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [6:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic probe(input string name, input logic [2:0] w, input logic [2:0] j,
                         input logic [6:0] cost, input logic tr, input logic ir,
                         input logic ld, input logic de, input logic [12:0] cs);
        exp_t e;
        W = w;
        J = j;
        e.name = name;
        e.cost = cost;
        e.tr   = tr;
        e.ir   = ir;
        e.ld   = ld;
        e.de   = de;
        e.cs   = cs;
        sb_q.push_back(e);
        probe_en = 1'b1;
        cycle();
        probe_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 7'd0;
        clear    = 1'b0;
        W        = 3'd0;
        J        = 3'd0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        probe("reset", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0);

        // Ramp load: entry k = (k*3) % 128.
        for (int k = 0; k < 10; k++) send(7'((k * 3) % 128));
        probe("partial10", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd135);
        for (int k = 10; k < 63; k++) send(7'((k * 3) % 128));
        probe("beat62", 3'd7, 3'd7, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd3299);
        send(7'd61);
        probe("ready", 3'd2, 3'd5, 7'd63, 1'b1, 1'b0, 1'b1, 1'b0, 13'd3360);
        probe("pulse_end", 3'd7, 3'd7, 7'd61, 1'b1, 1'b0, 1'b0, 1'b0, 13'd3360);

        // Offer a beat while READY: rejected, flagged, table untouched.
        in_valid = 1'b1;
        in_data  = 7'd99;
        probe("drop_cycle", 3'd7, 3'd7, 7'd61, 1'b1, 1'b0, 1'b0, 1'b0, 13'd3360);
        in_valid = 1'b0;
        probe("drop_err", 3'd7, 3'd7, 7'd61, 1'b1, 1'b0, 1'b0, 1'b1, 13'd3360);
        probe("cost_w1j0", 3'd1, 3'd0, 7'd24, 1'b1, 1'b0, 1'b0, 1'b1, 13'd3360);

        clear = 1'b1;
        probe("clear_cycle", 3'd0, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 13'd3360);
        clear = 1'b0;
        probe("after_clear", 3'd7, 3'd7, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0);

        // Partial load, clear, then full reload of ones.
        for (int k = 0; k < 30; k++) send(7'd5);
        probe("mid30", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd150);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int k = 0; k < 63; k++) send(7'd1);
        probe("ones_63", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd63);
        send(7'd1);
        probe("ones_ready", 3'd0, 3'd0, 7'd1, 1'b1, 1'b0, 1'b1, 1'b0, 13'd64);
        probe("ones_w7j7", 3'd7, 3'd7, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0, 13'd64);
        probe("ones_w3j4", 3'd3, 3'd4, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0, 13'd64);

        // clear together with in_valid: beat dropped, no drop_err.
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'd9;
        probe("clr_valid_ready", 3'd0, 3'd0, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0, 13'd64);
        probe("clr_valid_empty", 3'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 13'd0);
        clear    = 1'b0;
        in_valid = 1'b0;
        probe("clr_valid_after", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0);

        // Full-scale load; also proves the counter stayed at 0.
        for (int k = 0; k < 63; k++) send(7'd127);
        probe("max_63", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd8001);
        send(7'd127);
        probe("max_ready", 3'd5, 3'd2, 7'd127, 1'b1, 1'b0, 1'b1, 1'b0, 13'd8128);
        in_valid = 1'b1;
        in_data  = 7'd3;
        cycle();
        in_valid = 1'b0;
        probe("max_drop", 3'd0, 3'd0, 7'd127, 1'b1, 1'b0, 1'b0, 1'b1, 13'd8128);

        // Second load interrupted by RST (with a competing beat).
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int k = 0; k < 20; k++) send(7'd127);
        probe("second_load", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd2540);
        RST      = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'd127;
        cycle();
        RST      = 1'b0;
        in_valid = 1'b0;
        probe("post_rst", 3'd5, 3'd2, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0);
        send(7'd1);
        probe("rst_restart", 3'd0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd1);

        @(negedge CLK);
        check("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cost_table.md
COST_TABLE -- requirements
Module: cost_table

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high (one clock; reset is synchronous and active-high).
REQ-003 SHALL have port in_valid, input, 1 bit: loader presents a cost entry.
REQ-004 SHALL have port in_data, input, 7 bits: cost entry, unsigned 0..127.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts an entry this cycle.
REQ-006 SHALL have port clear, input, 1 bit: discard the table and restart loading.
REQ-007 SHALL have port W, input, 3 bits: worker index from the job assignment machine.
REQ-008 SHALL have port J, input, 3 bits: job index from the job assignment machine.
REQ-009 SHALL have port Cost, output, 7 bits: cost of worker W on job J.
REQ-010 SHALL have port table_ready, output, 1 bit: all 64 entries loaded; downstream may run.
REQ-011 SHALL have port load_done, output, 1 bit: one-cycle pulse on entry into READY.
REQ-012 SHALL have port drop_err, output, 1 bit: sticky flag, a beat was offered while not accepted.
REQ-013 SHALL have port checksum, output, 13 bits: sum of loaded entries (present only with COST_CHECKSUM_EN).

Function
REQ-014 SHALL store 64 entries of 7 bits in a register array indexed {worker[2:0], job[2:0]}.
REQ-015 SHALL implement states EMPTY, LOAD, READY.
REQ-016 SHALL accept a beat when in_valid && in_ready, on that clock edge.
REQ-017 SHALL drive in_ready = (state != READY) && !clear.
REQ-018 SHALL write accepted beat k (0..63, arrival order) to address k, i.e. W = k[5:3], J = k[2:0], row-major by worker.
REQ-019 SHALL keep a 6-bit write counter, reset to 0; it increments per accepted beat and wraps to 0 after beat 63.
REQ-020 SHALL transition EMPTY->LOAD on the first accepted beat.
REQ-021 SHALL transition LOAD->READY on acceptance of beat 63, directly from EMPTY never.
REQ-022 SHALL assert load_done for exactly the first cycle in which state is READY.
REQ-023 SHALL drive table_ready = (state == READY), registered.
REQ-024 SHALL drive Cost combinationally from the array at {W,J} when table_ready is 1 (zero-latency, same-cycle read), and 0 otherwise.
REQ-025 SHALL, on clear high at an edge in any state, go to EMPTY, zero the counter, and accept no beat that cycle; array contents need not be cleared.
REQ-026 SHALL, on clear and in_valid in the same cycle, drop the beat and not set drop_err.
REQ-027 SHALL set drop_err when in_valid is high in READY with clear low; it holds until RST or clear.
REQ-028 SHALL ignore W/J while not READY; reads never modify state.

Reset
REQ-029 SHALL on RST: state EMPTY, counter 0, table_ready 0, load_done 0, drop_err 0, checksum 0, Cost 0; in_ready reads 1 after reset when clear is low.
REQ-030 SHALL give RST priority over clear and in_valid; RST mid-load abandons the partial table.

Configuration
REQ-031 SHALL, with macro COST_CHECKSUM_EN defined, add 13-bit checksum accumulating each accepted in_data, cleared by RST/clear; max 64*127 = 8128, no overflow.
REQ-032 SHALL, without COST_CHECKSUM_EN, omit the checksum port and adder; all other behaviour is identical.

Verification
REQ-033 Load entries k -> value (k*3)%128 for k = 0..63 -> table_ready rises the cycle after beat 63; load_done is 1 for one cycle; W=2, J=5 gives Cost=63.
REQ-034 Before load completes, W=0, J=0 -> Cost=0; after 10 beats, table_ready=0 and in_ready=1.
REQ-035 In READY, in_valid=1 with data 99 -> not accepted; drop_err=1; Cost at {7,7} is unchanged.
REQ-036 Clear after 30 beats, then reload 64 beats of value 1 -> first new beat lands at address 0; all Cost=1; with COST_CHECKSUM_EN, checksum=64.
REQ-037 Clear and in_valid asserted in the same cycle -> in_ready=0; counter stays 0; drop_err stays 0.
REQ-038 Load all 127s with COST_CHECKSUM_EN -> checksum=8128; assert RST mid-second-load -> all outputs return to their reset values.
